// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch front end.
package inst_fetch_queue_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT  = 4;

  // One decoded-side queue entry: fetched word, its PC and address-error flag.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with push/pop/flush and an occupancy count.
// Flush has priority over push and pop; push while full is ignored unless popping.
module fetch_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Qualify push/pop against flush and occupancy, then advance pointers and count.
  always_comb begin
    do_pop   = pop && !flush && (count_q != '0);
    do_push  = push && !flush && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push && !do_pop) count_d = count_q + CW'(1);
      if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
  end

  // Pointer and count state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues requests on an
// SRAM-like port and queues returned words with their PCs for decode.
// Optional feature macro: FETCH_ADEL_CHECK_EN (misaligned-PC address error entries).
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned QDEPTH   = 4,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
`ifdef FETCH_ADEL_CHECK_EN
  ,
  output logic        out_adel
`endif
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic          run_q;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] q_count;
  logic [CW-1:0] unused_pend_count;
  logic [31:0]   pend_pc;
  logic          credit, fetch_en, accept, resp, resp_keep;
  logic          q_push, q_pop;
  entry_t        q_wentry, head_entry;

  // Discarded responses still hold credit until they return.
  assign credit = ({1'b0, q_count} + {1'b0, outstanding_q}) < (CW + 1)'(QDEPTH);

`ifdef FETCH_ADEL_CHECK_EN
  logic misaligned, adel_push, adel_stall_q, adel_stall_d;

  assign misaligned = (pc_q[1:0] != 2'b00);
  assign fetch_en   = !misaligned && !adel_stall_q;
  assign adel_push  = run_q && misaligned && !adel_stall_q && credit && !redirect_valid;

  // Once the error entry is queued, fetch stays parked until a redirect.
  always_comb begin
    adel_stall_d = adel_stall_q;
    if (redirect_valid) adel_stall_d = 1'b0;
    else if (adel_push) adel_stall_d = 1'b1;
  end

  // Address-error stall flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) adel_stall_q <= 1'b0;
    else         adel_stall_q <= adel_stall_d;
  end

  // Real responses and the error entry never coincide: a misaligned PC only
  // follows a redirect, so every response in flight is being discarded.
  always_comb begin
    q_wentry = '{pc: pend_pc, instr: inst_rdata, adel: 1'b0};
    if (!resp_keep) q_wentry = '{pc: pc_q, instr: NOP_WORD, adel: 1'b1};
  end

  assign q_push   = resp_keep || adel_push;
  assign out_adel = out_valid && head_entry.adel;
`else
  logic unused_head_adel;

  assign fetch_en         = 1'b1;
  assign q_wentry         = '{pc: pend_pc, instr: inst_rdata, adel: 1'b0};
  assign q_push           = resp_keep;
  assign unused_head_adel = head_entry.adel;
`endif

  assign inst_addr = pc_q;
  assign inst_req  = run_q && credit && fetch_en;
  assign accept    = inst_req && inst_addr_ok;
  assign resp      = inst_data_ok && (outstanding_q != '0);
  // A response is kept only when nothing is pending discard and no redirect flushes it.
  assign resp_keep = resp && (discard_q == '0) && !redirect_valid;
  assign q_pop     = out_valid && out_ready;

  // Next PC, outstanding and discard counts; redirect overrides the step.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (accept && !resp) outstanding_d = outstanding_q + CW'(1);
    if (!accept && resp) outstanding_d = outstanding_q - CW'(1);
    if (redirect_valid) begin
      pc_d      = redirect_pc;
      discard_d = outstanding_d;
    end else begin
      if (accept) pc_d = pc_q + 32'(PC_STEP);
      if (resp && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end
  end

  // Fetch control state; run_q delays the first request to the cycle after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q          <= RESET_PC;
      run_q         <= 1'b0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      run_q         <= 1'b1;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (QDEPTH)
  ) u_pend_fifo (
    .clk    (clk),
    .resetn (resetn),
    .flush  (redirect_valid),
    .push   (accept),
    .wdata  (pc_q),
    .pop    (resp_keep),
    .rdata  (pend_pc),
    .count  (unused_pend_count)
  );

  fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (QDEPTH)
  ) u_inst_queue (
    .clk    (clk),
    .resetn (resetn),
    .flush  (redirect_valid),
    .push   (q_push),
    .wdata  (q_wentry),
    .pop    (q_pop),
    .rdata  (head_entry),
    .count  (q_count)
  );

  assign out_valid = (q_count != '0);
  assign out_instr = out_valid ? head_entry.instr : 32'h0;
  assign out_pc    = out_valid ? head_entry.pc : 32'h0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed vector table, hand-written
// redirect/reset sequences and randomized traffic against a queue-based model.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam int          QD     = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic [31:0] inst_rdata = 32'h0;
  logic        inst_data_ok = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;
`ifdef FETCH_ADEL_CHECK_EN
  logic        out_adel;
`endif

  always #5 clk = ~clk;

  inst_fetch_queue dut (
    .clk            (clk),
    .resetn         (resetn),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_rdata     (inst_rdata),
    .inst_data_ok   (inst_data_ok),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready)
`ifdef FETCH_ADEL_CHECK_EN
    ,
    .out_adel       (out_adel)
`endif
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          adel;
  } mentry_t;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } mreq_t;

  typedef struct {
    bit          aok;
    bit          dok;
    bit          rdy;
    bit          req;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] pc;
  } vec_t;

  // Reference model: decoder-visible queue, in-flight requests, fetch PC.
  mentry_t     mq[$];
  mreq_t       mo[$];
  logic [31:0] slave[$];
  logic [31:0] mpc;
  bit          mrun;
  bit          mstall;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit model_req();
    bit r;
    r = mrun && ((mq.size() + mo.size()) < QD);
`ifdef FETCH_ADEL_CHECK_EN
    r = r && (mpc[1:0] == 2'b00) && !mstall;
`endif
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    mo.delete();
    slave.delete();
    mpc    = RST_PC;
    mrun   = 1'b0;
    mstall = 1'b0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_update();
    bit      req, acc, credit;
    mreq_t   r;
    mentry_t e;
    req    = model_req();
    acc    = req && inst_addr_ok;
    credit = (mq.size() + mo.size()) < QD;
    // Slave environment follows what the DUT actually issues.
    if (inst_data_ok && slave.size() > 0) void'(slave.pop_front());
    if (inst_req && inst_addr_ok) slave.push_back(inst_addr);
    if (mq.size() > 0 && out_ready && !redirect_valid) void'(mq.pop_front());
    if (inst_data_ok && mo.size() > 0) begin
      r = mo.pop_front();
      if (!r.stale && !redirect_valid) begin
        e.pc = r.pc; e.instr = imem(r.pc); e.adel = 1'b0;
        mq.push_back(e);
      end
    end
`ifdef FETCH_ADEL_CHECK_EN
    if (mrun && mpc[1:0] != 2'b00 && !mstall && credit && !redirect_valid) begin
      e.pc = mpc; e.instr = 32'h0; e.adel = 1'b1;
      mq.push_back(e);
      mstall = 1'b1;
    end
`else
    if (credit) begin end
`endif
    if (acc) begin
      r.pc = mpc; r.stale = redirect_valid;
      mo.push_back(r);
    end
    if (redirect_valid) begin
      mq.delete();
      foreach (mo[i]) mo[i].stale = 1'b1;
      mpc    = redirect_pc;
      mstall = 1'b0;
    end else if (acc) begin
      mpc = mpc + 32'd4;
    end
    mrun = 1'b1;
  endtask

  task automatic model_check();
    bit req;
    req = model_req();
    check("m_req", inst_req, req);
    if (req) check("m_addr", inst_addr, mpc);
    check("m_valid", out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      check("m_pc", out_pc, mq[0].pc);
      check("m_instr", out_instr, mq[0].instr);
`ifdef FETCH_ADEL_CHECK_EN
      check("m_adel", out_adel, mq[0].adel);
`endif
    end
  endtask

  // Drive one cycle of inputs (data_ok only when the slave holds a request).
  task automatic cyc(input bit aok, input bit dok_en, input bit rdy, input bit redir,
                     input logic [31:0] rpc);
    inst_addr_ok   = aok;
    inst_data_ok   = dok_en && (slave.size() > 0);
    inst_rdata     = inst_data_ok ? imem(slave[0]) : 32'hDEAD_BEEF;
    out_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    model_update();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req"}, inst_req, 1'b0);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_instr"}, out_instr, 32'h0);
    check({tag, "_pc"}, out_pc, 32'h0);
    check({tag, "_addr"}, inst_addr, RST_PC);
  endtask

  // Run until the first entry appears, then check its PC and word.
  task automatic wait_first(input string tag, input logic [31:0] exp_pc,
                            input logic [31:0] exp_instr);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      seen = out_valid;
    end
    check({tag, "_seen"}, seen, 1'b1);
    if (seen) begin
      check({tag, "_pc"}, out_pc, exp_pc);
      check({tag, "_instr"}, out_instr, exp_instr);
    end
  endtask

  vec_t vt[11];

  initial begin
    vt[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hBFC0_0000, 1'b0, 32'h0};
    vt[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hBFC0_0004, 1'b0, 32'h0};
    vt[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hBFC0_0008, 1'b1, 32'hBFC0_0000};
    vt[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hBFC0_000C, 1'b1, 32'hBFC0_0004};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hBFC0_0010, 1'b1, 32'hBFC0_0004};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hBFC0_0014, 1'b1, 32'hBFC0_0004};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hBFC0_0014, 1'b1, 32'hBFC0_0004};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hBFC0_0014, 1'b1, 32'hBFC0_0004};
    vt[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hBFC0_0014, 1'b1, 32'hBFC0_0008};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hBFC0_0018, 1'b1, 32'hBFC0_0008};
    vt[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hBFC0_0018, 1'b1, 32'hBFC0_0008};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_idle("rst0");
    resetn = 1'b1;
    #1;
    check_idle("rel0");

    // Directed table: steady streaming, then back-pressure filling the queue.
    for (int i = 0; i < 11; i++) begin
      cyc(vt[i].aok, vt[i].dok, vt[i].rdy, 1'b0, 32'h0);
      check($sformatf("tbl%0d_req", i), inst_req, vt[i].req);
      check($sformatf("tbl%0d_addr", i), inst_addr, vt[i].addr);
      check($sformatf("tbl%0d_valid", i), out_valid, vt[i].vld);
      if (vt[i].vld) begin
        check($sformatf("tbl%0d_pc", i), out_pc, vt[i].pc);
        check($sformatf("tbl%0d_instr", i), out_instr, imem(vt[i].pc));
      end
    end

    // Redirect with two requests in flight.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("rd_req_before", inst_req, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_1000);
    check("rd_addr", inst_addr, 32'h8000_1000);
    check("rd_valid", out_valid, 1'b0);
    check("rd_req", inst_req, 1'b1);
    wait_first("rd_first", 32'h8000_1000, imem(32'h8000_1000));

    // Redirect coinciding with a response and an accepted request.
    repeat (6) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("sc_req", inst_req, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h8000_2000);
    check("sc_addr", inst_addr, 32'h8000_2000);
    check("sc_valid", out_valid, 1'b0);
    wait_first("sc_first", 32'h8000_2000, imem(32'h8000_2000));

    // Asynchronous reset in the middle of traffic.
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    resetn = 1'b0;
    #1;
    check_idle("mid_rst");
    model_reset();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("mid_rst_req", inst_req, 1'b1);
    check("mid_rst_addr", inst_addr, RST_PC);

`ifdef FETCH_ADEL_CHECK_EN
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0002);
    check("adel_req", inst_req, 1'b0);
    wait_first("adel_first", 32'h8000_0002, 32'h0);
    check("adel_flag", out_adel, 1'b1);
    check("adel_stall", inst_req, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0100);
    check("adel_resume", inst_req, 1'b1);
    wait_first("adel_next", 32'h8000_0100, imem(32'h8000_0100));
    check("adel_clear", out_adel, 1'b0);
`endif

    // Randomized traffic against the model, including PC wrap targets.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rpc;
      rpc = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF8;
`ifdef FETCH_ADEL_CHECK_EN
      if ($urandom_range(0, 7) == 0) rpc = rpc | 32'h2;
`endif
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0,
          $urandom_range(0, 15) == 0, rpc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
